// File: rtl/pio_in_edge.sv
// Avalon-MM parallel input port: synchronises, optionally debounces, and edge-captures
// external inputs, with a maskable level interrupt and write-1-to-clear capture register.
module pio_in_edge #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_bits;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_d;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] edgecap_next;
    logic [WIDTH-1:0] w1c;
    logic [31:0]      rd_next;
    logic             wr_en;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;

    // NOTE: the sync chain is a handful of flops, not a RAM, so every stage is reset
    // explicitly; a memory-style array without reset would start as X in simulation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            // NOTE: non-blocking assignments let each stage sample the previous stage's
            // old value; blocking here would collapse the chain into a single flop.
            sync_q[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign sync_bits = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
            assign deb = sync_bits;
        end else begin : g_debounce
            localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
            logic [WIDTH-1:0] sync_d;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) sync_d <= '0;
                else       sync_d <= sync_bits;
            end

            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                logic [15:0] cnt_q;
                logic [15:0] cnt_next;
                logic        deb_bit;

                // Any bounce restarts the stability window; agreement idles the counter.
                always_comb begin
                    cnt_next = cnt_q + 16'd1;
                    if (sync_bits[i] == deb_bit || sync_bits[i] != sync_d[i])
                        cnt_next = '0;
                end

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        cnt_q   <= '0;
                        deb_bit <= 1'b0;
                    end else begin
                        cnt_q <= cnt_next;
                        if (cnt_next == DB_LAST) deb_bit <= sync_bits[i];
                    end
                end

                assign deb[i] = deb_bit;
            end
        end
    endgenerate

    // NOTE: every output of a combinational block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        edges = deb ^ deb_d;
        if (EDGE_TYPE == 0)      edges = deb & ~deb_d;
        else if (EDGE_TYPE == 1) edges = ~deb & deb_d;
    end

    assign wr_en = chipselect & write;
    assign w1c   = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // A fresh edge overrides a simultaneous clear so no event is lost.
    assign edgecap_next = (edgecap_q & ~w1c) | edges;

    always_comb begin
        rd_next = '0;
        case (address)
            2'd0:    rd_next[WIDTH-1:0] = deb;
            2'd2:    rd_next[WIDTH-1:0] = irqmask_q;
            2'd3:    rd_next[WIDTH-1:0] = edgecap_q;
            default: rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_d     <= '0;
            irqmask_q <= '0;
            edgecap_q <= '0;
            readdata  <= '0;
            irq       <= 1'b0;
        end else begin
            deb_d     <= deb;
            edgecap_q <= edgecap_next;
            readdata  <= rd_next;
            irq       <= |(edgecap_q & irqmask_q);
            if (wr_en && address == 2'd2) irqmask_q <= writedata[WIDTH-1:0];
        end
    end

endmodule

// File: doc/pio_in_edge.md
PIO_IN_EDGE -- requirements
Module: pio_in_edge

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning input port width, legal range 1..32.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning synchroniser flop count, legal range 2..4.
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 0, meaning stable-cycle count before an input change is accepted; 0 = bypass, legal range 0..65535.
REQ-004 The block SHALL have parameter EDGE_TYPE, default 0, meaning capture mode: 0 = rising, 1 = falling, 2 = any edge.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port address, input, 2 bits: Avalon-MM word address.
REQ-008 The block SHALL have port chipselect, input, 1 bit: slave select.
REQ-009 The block SHALL have port write, input, 1 bit: write strobe, active-high, qualified by chipselect.
REQ-010 The block SHALL have port writedata, input, 32 bits: write data.
REQ-011 The block SHALL have port in_port, input, WIDTH bits: asynchronous external inputs.
REQ-012 The block SHALL have port readdata, output, 32 bits: registered read data.
REQ-013 The block SHALL have port irq, output, 1 bit: registered level interrupt, active-high.

Function
REQ-014 in_port SHALL pass through SYNC_STAGES flops per bit before any other use.
REQ-015 Debounce, per bit: a 16-bit counter SHALL clear whenever the synchronised bit equals the debounced value or changes, and otherwise increment; the debounced bit SHALL take the synchronised value on the cycle the counter reaches DEBOUNCE_CYCLES-1.
REQ-016 With DEBOUNCE_CYCLES = 0, the debounced value SHALL equal the synchronised value and the counters SHALL NOT be generated.
REQ-017 Edge detect SHALL compare the debounced value with a one-cycle-delayed copy, using the sense selected by EDGE_TYPE; each detected edge SHALL set its edgecapture bit on the following clock.
REQ-018 Register map, address 0, data: read-only, debounced value in bits [WIDTH-1:0]; writes ignored.
REQ-019 Register map, address 1: reserved; reads return 0 and writes are ignored.
REQ-020 Register map, address 2, irqmask: read/write, bits [WIDTH-1:0].
REQ-021 Register map, address 3, edgecapture: read plus write-1-to-clear of bits [WIDTH-1:0].
REQ-022 Unused readdata bits SHALL read 0.
REQ-023 Writes SHALL take effect on the clock where chipselect and write are both 1; zero wait states.
REQ-024 readdata SHALL be registered every clock from the address mux, independent of chipselect, giving read latency 1.
REQ-025 irq SHALL be registered as the OR-reduction of (edgecapture AND irqmask); irq asserts 1 clock after the qualifying edgecapture bit sets.
REQ-026 When an edge is detected in the same cycle as a W1C write to the same bit, the set SHALL win and the bit remains 1.
REQ-027 A write to irqmask SHALL affect irq from the next clock onward; clearing a mask bit deasserts irq 1 clock later if no other masked bit is set.
REQ-028 Total latency from a clean in_port transition to edgecapture set SHALL be SYNC_STAGES + DEBOUNCE_CYCLES + 1 clocks (DEBOUNCE_CYCLES = 0: SYNC_STAGES + 1).

Reset
REQ-029 Asserting reset SHALL immediately clear the sync flops, debounced value, delayed copy, debounce counters, irqmask, edgecapture, readdata and irq to 0.
REQ-030 Reset asserted mid-debounce SHALL discard the pending change.
REQ-031 After reset release, an input held high SHALL be seen as a 0-to-1 transition and captured when EDGE_TYPE is 0 or 2; this behaviour is defined, not an error.

Verification
REQ-032 Defaults, in_port 0000->0101, read address 0 -> readdata 0x00000005 no later than 4 clocks after the change.
REQ-033 EDGE_TYPE = 0, irqmask = 0x1, bit 0 rises -> edgecapture = 0x1 and irq = 1; write 0x1 to address 3 -> edgecapture = 0 and irq = 0 one clock later.
REQ-034 DEBOUNCE_CYCLES = 8, bit 1 glitch lasting 5 clocks -> data unchanged and edgecapture = 0; a pulse held 8 clocks -> data bit 1 = 1 and edgecapture = 0x2.
REQ-035 W1C of bit 2 on the same cycle a new bit-2 edge is detected -> edgecapture bit 2 remains 1.
REQ-036 EDGE_TYPE = 2, WIDTH = 32, toggle all bits -> edgecapture = 0xFFFFFFFF; irqmask = 0 -> irq stays 0.
REQ-037 Reset asserted mid-operation with edgecapture = 0x3 and irq = 1 -> all registers 0 and irq = 0 within the same cycle, without waiting for a clock edge.
